// File: rtl/spi_arb_pkg.sv
// Shared types and sizing helpers for the SPI bus arbiter.
// Holds the sequencer state encoding and counter widths.
package spi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        RUN   = 2'd2,
        HOLD  = 2'd3
    } arb_state_e;

    // Timeout counter is sized for TIMEOUT_CYCLES up to 65536.
    localparam int TO_CNT_W    = 16;
    localparam int PHASE_CNT_W = 8;

    function automatic int len_width(input int max_bytes);
        return (max_bytes < 1) ? 1 : $clog2(max_bytes + 1);
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
// Returns a one-hot winner, its index and a found flag.
module rr_priority_pick #(
    parameter  int N     = 2,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [N-1:0]     win_onehot,
    output logic [IDX_W-1:0] win_idx
);

    logic [IDX_W:0]   sum      [N];
    logic [IDX_W-1:0] cand_idx [N];

    // cand_idx[gi] is the requester examined at priority position gi
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cand
            assign sum[gi]      = {1'b0, ptr} + (IDX_W+1)'(gi);
            assign cand_idx[gi] = (sum[gi] >= (IDX_W+1)'(N)) ?
                                  IDX_W'(sum[gi] - (IDX_W+1)'(N)) :
                                  sum[gi][IDX_W-1:0];
        end
    endgenerate

    always_comb begin
        found      = 1'b0;
        win_onehot = '0;
        win_idx    = '0;
        for (int off = 0; off < N; off++) begin
            if (!found && req[cand_idx[off]]) begin
                found                       = 1'b1;
                win_onehot[cand_idx[off]]   = 1'b1;
                win_idx                     = cand_idx[off];
            end
        end
    end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one SPI shift engine between NUM_REQ requesters.
// Sequences CS setup, engine start, completion/timeout and a CS hold gap.
module spi_bus_arbiter
    import spi_arb_pkg::*;
#(
    parameter  int NUM_REQ            = 2,
    parameter  int ADD_range          = 7,
    parameter  int num_of_bytes_asked = 3,
    parameter  int CS_SETUP           = 2,
    parameter  int CS_HOLD            = 2,
    parameter  int TIMEOUT_CYCLES     = 1024,
    localparam int LEN_W              = len_width(num_of_bytes_asked)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*ADD_range-1:0] req_addr,
    input  logic [NUM_REQ*LEN_W-1:0]     req_len,
    output logic [NUM_REQ-1:0]           gnt,
    output logic [NUM_REQ-1:0]           done,
    output logic                         err,
    output logic [ADD_range-1:0]         CS_address,
    output logic                         CS_spi,
    output logic                         spi_start,
    output logic [LEN_W-1:0]             spi_len,
    output logic                         spi_abort,
    input  logic                         spi_done
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0]       LAST_IDX   = IDX_W'(NUM_REQ - 1);
    localparam logic [LEN_W:0]         MAX_LEN    = (LEN_W+1)'(num_of_bytes_asked);
    localparam logic [PHASE_CNT_W-1:0] SETUP_LAST = PHASE_CNT_W'(CS_SETUP - 1);
    localparam logic [PHASE_CNT_W-1:0] HOLD_LAST  = PHASE_CNT_W'(CS_HOLD - 1);
    localparam logic [TO_CNT_W-1:0]    TO_LAST    = TO_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [ADD_range-1:0] addr_arr [NUM_REQ];
    logic [LEN_W-1:0]     len_arr  [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi] = req_addr[gi*ADD_range +: ADD_range];
            assign len_arr[gi]  = req_len[gi*LEN_W +: LEN_W];
        end
    endgenerate

    arb_state_e               state_q, state_d;
    logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]       gnt_q, gnt_d;
    logic [NUM_REQ-1:0]       done_q, done_d;
    logic                     err_q, err_d;
    logic [ADD_range-1:0]     cs_addr_q, cs_addr_d;
    logic                     cs_n_q, cs_n_d;
    logic                     spi_start_q, spi_start_d;
    logic [LEN_W-1:0]         spi_len_q, spi_len_d;
    logic                     spi_abort_q, spi_abort_d;
    logic [PHASE_CNT_W-1:0]   phase_cnt_q, phase_cnt_d;
    logic [TO_CNT_W-1:0]      to_cnt_q, to_cnt_d;

    logic                     pick_found;
    logic [NUM_REQ-1:0]       pick_onehot;
    logic [IDX_W-1:0]         pick_idx;
    logic [ADD_range-1:0]     win_addr;
    logic [LEN_W-1:0]         win_len;

    rr_priority_pick #(
        .N(NUM_REQ)
    ) u_pick (
        .req        (req),
        .ptr        (rr_ptr_q),
        .found      (pick_found),
        .win_onehot (pick_onehot),
        .win_idx    (pick_idx)
    );

    assign win_addr = addr_arr[pick_idx];
    assign win_len  = len_arr[pick_idx];

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_d       = gnt_q;
        done_d      = '0;
        err_d       = 1'b0;
        cs_addr_d   = cs_addr_q;
        cs_n_d      = cs_n_q;
        spi_start_d = 1'b0;
        spi_len_d   = spi_len_q;
        spi_abort_d = 1'b0;
        phase_cnt_d = phase_cnt_q;
        to_cnt_d    = to_cnt_q;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    gnt_d     = pick_onehot;
                    cs_addr_d = win_addr;
                    rr_ptr_d  = (pick_idx == LAST_IDX) ? '0 : pick_idx + IDX_W'(1);
                    // Empty or oversized transfers complete at once without touching CS;
                    // HOLD is entered on its last count so it lasts a single cycle.
                    if (win_len == '0 || {1'b0, win_len} > MAX_LEN) begin
                        done_d      = pick_onehot;
                        err_d       = (win_len != '0);
                        phase_cnt_d = HOLD_LAST;
                        state_d     = HOLD;
                    end else begin
                        cs_n_d      = 1'b0;
                        spi_len_d   = win_len;
                        phase_cnt_d = '0;
                        state_d     = SETUP;
                    end
                end
            end
            SETUP: begin
                if (phase_cnt_q == SETUP_LAST) begin
                    spi_start_d = 1'b1;
                    to_cnt_d    = '0;
                    state_d     = RUN;
                end else begin
                    phase_cnt_d = phase_cnt_q + PHASE_CNT_W'(1);
                end
            end
            RUN: begin
                // spi_done is tested first so a completion on the timeout cycle is not an error
                if (spi_done || to_cnt_q == TO_LAST) begin
                    done_d      = gnt_q;
                    err_d       = !spi_done;
                    spi_abort_d = !spi_done;
                    cs_n_d      = 1'b1;
                    phase_cnt_d = '0;
                    state_d     = HOLD;
                end else begin
                    to_cnt_d = to_cnt_q + TO_CNT_W'(1);
                end
            end
            HOLD: begin
                gnt_d = '0;
                if (phase_cnt_q == HOLD_LAST) begin
                    state_d = IDLE;
                end else begin
                    phase_cnt_d = phase_cnt_q + PHASE_CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            err_q       <= 1'b0;
            cs_addr_q   <= '0;
            cs_n_q      <= 1'b1;
            spi_start_q <= 1'b0;
            spi_len_q   <= '0;
            spi_abort_q <= 1'b0;
            phase_cnt_q <= '0;
            to_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cs_addr_q   <= cs_addr_d;
            cs_n_q      <= cs_n_d;
            spi_start_q <= spi_start_d;
            spi_len_q   <= spi_len_d;
            spi_abort_q <= spi_abort_d;
            phase_cnt_q <= phase_cnt_d;
            to_cnt_q    <= to_cnt_d;
        end
    end

    assign gnt        = gnt_q;
    assign done       = done_q;
    assign err        = err_q;
    assign CS_address = cs_addr_q;
    assign CS_spi     = cs_n_q;
    assign spi_start  = spi_start_q;
    assign spi_len    = spi_len_q;
    assign spi_abort  = spi_abort_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Scoreboard bench for spi_bus_arbiter: expected completions are queued at
// stimulus time and matched against done/err/spi_abort as they appear.
module tb_spi_bus_arbiter;

    localparam int NUM_REQ  = 2;
    localparam int ADD_W    = 7;
    localparam int NBYTES   = 6;
    localparam int LEN_W    = 3;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int TIMEOUT  = 1024;

    logic                       clk = 1'b0;
    logic                       reset;
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ*ADD_W-1:0]   req_addr;
    logic [NUM_REQ*LEN_W-1:0]   req_len;
    logic [NUM_REQ-1:0]         gnt;
    logic [NUM_REQ-1:0]         done;
    logic                       err;
    logic [ADD_W-1:0]           cs_address;
    logic                       cs_spi;
    logic                       spi_start;
    logic [LEN_W-1:0]           spi_len;
    logic                       spi_abort;
    logic                       spi_done;

    typedef struct packed {
        logic [NUM_REQ-1:0] done_vec;
        logic               err;
        logic               abort;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks_cnt = 0;
    int   errors_cnt = 0;
    int   eng_delay  = 0;
    int   eng_n;

    always #5 clk = ~clk;

    spi_bus_arbiter #(
        .NUM_REQ            (NUM_REQ),
        .ADD_range          (ADD_W),
        .num_of_bytes_asked (NBYTES),
        .CS_SETUP           (CS_SETUP),
        .CS_HOLD            (CS_HOLD),
        .TIMEOUT_CYCLES     (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .gnt        (gnt),
        .done       (done),
        .err        (err),
        .CS_address (cs_address),
        .CS_spi     (cs_spi),
        .spi_start  (spi_start),
        .spi_len    (spi_len),
        .spi_abort  (spi_abort),
        .spi_done   (spi_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks_cnt++;
        if (obs !== exp_v) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic logic cond(input int what);
        case (what)
            0:       return gnt != '0;
            1:       return spi_start;
            2:       return done != '0;
            default: return gnt == '0;
        endcase
    endfunction

    task automatic wait_for(input int what, input int budget, output int cyc);
        cyc = 0;
        while (!cond(what) && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        chk($sformatf("wait%0d_seen", what), 32'(cond(what)), 32'd1);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [ADD_W-1:0] a, input logic [LEN_W-1:0] l);
        req_addr[i*ADD_W +: ADD_W] = a;
        req_len[i*LEN_W +: LEN_W]  = l;
    endtask

    task automatic push_exp(input logic [NUM_REQ-1:0] d, input logic e, input logic ab);
        exp_t x;
        x.done_vec = d;
        x.err      = e;
        x.abort    = ab;
        sb_q.push_back(x);
    endtask

    function automatic int model_pick(input logic [NUM_REQ-1:0] r, input int p);
        for (int off = 0; off < NUM_REQ; off++) begin
            if (r[(p + off) % NUM_REQ]) return (p + off) % NUM_REQ;
        end
        return -1;
    endfunction

    // Engine model: pulse spi_done eng_delay edges after spi_start (0 = never).
    initial begin
        spi_done = 1'b0;
        forever begin
            @(negedge clk);
            if (spi_start && eng_delay > 0) begin
                eng_n = 1;
                while (eng_n < eng_delay && !reset) begin
                    @(negedge clk);
                    eng_n++;
                end
                if (!reset) begin
                    spi_done = 1'b1;
                    @(negedge clk);
                    spi_done = 1'b0;
                end
            end
        end
    end

    // Monitor: invariants every cycle, scoreboard match on each done pulse.
    always @(negedge clk) begin
        if (!reset) begin
            chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            if (!cs_spi) chk("gnt_while_cs_low", 32'(gnt != '0), 32'd1);
            if (done != '0) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_done", 32'(done), 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("sb_done", 32'(done), 32'(mon_e.done_vec));
                    chk("sb_err", 32'(err), 32'(mon_e.err));
                    chk("sb_abort", 32'(spi_abort), 32'(mon_e.abort));
                    chk("sb_gnt_at_done", 32'(gnt), 32'(mon_e.done_vec));
                    $display("txn done=%b err=%b abort=%b addr=0x%0h t=%0t",
                             done, err, spi_abort, cs_address, $time);
                end
            end else begin
                chk("err_abort_without_done", 32'({err, spi_abort}), 32'd0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cyc;
        int ptr_m;
        int w;
        logic [NUM_REQ-1:0] exp_order [4];

        reset    = 1'b1;
        req      = '0;
        req_addr = '0;
        req_len  = '0;
        step(3);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_cs_address", 32'(cs_address), 32'd0);
        chk("rst_cs_spi", 32'(cs_spi), 32'd1);
        chk("rst_spi_start", 32'(spi_start), 32'd0);
        chk("rst_spi_len", 32'(spi_len), 32'd0);
        chk("rst_spi_abort", 32'(spi_abort), 32'd0);
        reset = 1'b0;

        // Single request, engine completes 30 edges after start
        set_req(0, 7'h2A, 3'd3);
        req       = 2'b01;
        eng_delay = 30;
        push_exp(2'b01, 1'b0, 1'b0);
        step(1);
        chk("t1_gnt", 32'(gnt), 32'h1);
        chk("t1_cs_low", 32'(cs_spi), 32'd0);
        chk("t1_cs_address", 32'(cs_address), 32'h2A);
        chk("t1_spi_len", 32'(spi_len), 32'd3);
        chk("t1_no_start_yet", 32'(spi_start), 32'd0);
        req = 2'b00;
        step(1);
        chk("t1_setup_no_start", 32'(spi_start), 32'd0);
        step(1);
        chk("t1_start_after_setup", 32'(spi_start), 32'd1);
        step(1);
        chk("t1_start_one_cycle", 32'(spi_start), 32'd0);
        wait_for(2, 100, cyc);
        chk("t1_done_latency", 32'(cyc + 1), 32'd30);
        chk("t1_cs_high_at_done", 32'(cs_spi), 32'd1);

        // Zero-length request during HOLD: not sampled until IDLE
        set_req(0, 7'h11, 3'd0);
        req = 2'b01;
        push_exp(2'b01, 1'b0, 1'b0);
        step(1);
        chk("t1_hold1_gnt", 32'(gnt), 32'd0);
        chk("t1_hold1_cs", 32'(cs_spi), 32'd1);
        step(1);
        chk("t1_hold2_gnt", 32'(gnt), 32'd0);
        step(1);
        chk("len0_gnt", 32'(gnt), 32'h1);
        chk("len0_done", 32'(done), 32'h1);
        chk("len0_cs", 32'(cs_spi), 32'd1);
        req = 2'b00;
        step(1);
        chk("len0_gnt_drop", 32'(gnt), 32'd0);
        chk("len0_no_start", 32'(spi_start), 32'd0);
        chk("len0_cs_still_high", 32'(cs_spi), 32'd1);

        // Contention with both requests held
        do_reset();
        eng_delay = 3;
        set_req(0, 7'h10, 3'd1);
        set_req(1, 7'h21, 3'd1);
        req   = 2'b11;
        ptr_m = 0;
        for (int k = 0; k < 4; k++) begin
            w = model_pick(2'b11, ptr_m);
            exp_order[k] = NUM_REQ'(1 << w);
            push_exp(exp_order[k], 1'b0, 1'b0);
            ptr_m = (w + 1) % NUM_REQ;
        end
        for (int k = 0; k < 4; k++) begin
            wait_for(0, 50, cyc);
            chk($sformatf("t2_gnt_%0d", k), 32'(gnt), 32'(exp_order[k]));
            chk($sformatf("t2_addr_%0d", k), 32'(cs_address),
                (exp_order[k] == 2'b01) ? 32'h10 : 32'h21);
            if (k == 3) req = 2'b00;
            wait_for(3, 100, cyc);
        end

        // Timeout on requester 1
        set_req(1, 7'h55, 3'd2);
        req       = 2'b10;
        eng_delay = 0;
        push_exp(2'b10, 1'b1, 1'b1);
        wait_for(0, 20, cyc);
        chk("t3_gnt", 32'(gnt), 32'h2);
        req = 2'b00;
        wait_for(1, 20, cyc);
        wait_for(2, 1100, cyc);
        chk("t3_timeout_latency", 32'(cyc), 32'(TIMEOUT));
        chk("t3_abort", 32'(spi_abort), 32'd1);
        chk("t3_err", 32'(err), 32'd1);
        chk("t3_cs_high", 32'(cs_spi), 32'd1);
        step(1);
        chk("t3_gnt_drop", 32'(gnt), 32'd0);
        step(2);

        // Oversized length: done+err, no CS activity
        set_req(0, 7'h33, 3'd7);
        req = 2'b01;
        push_exp(2'b01, 1'b1, 1'b0);
        step(1);
        chk("ovf_gnt", 32'(gnt), 32'h1);
        chk("ovf_done", 32'(done), 32'h1);
        chk("ovf_err", 32'(err), 32'd1);
        chk("ovf_cs", 32'(cs_spi), 32'd1);
        req = 2'b00;
        step(1);
        chk("ovf_no_start", 32'(spi_start), 32'd0);
        chk("ovf_cs_still_high", 32'(cs_spi), 32'd1);

        // Race: spi_done lands on the timeout edge, max legal length
        set_req(0, 7'h7F, 3'd6);
        req       = 2'b01;
        eng_delay = TIMEOUT;
        push_exp(2'b01, 1'b0, 1'b0);
        wait_for(0, 20, cyc);
        chk("race_spi_len", 32'(spi_len), 32'd6);
        req = 2'b00;
        wait_for(1, 20, cyc);
        wait_for(2, 1100, cyc);
        chk("race_latency", 32'(cyc), 32'(TIMEOUT));
        chk("race_no_err", 32'(err), 32'd0);
        chk("race_no_abort", 32'(spi_abort), 32'd0);
        step(3);

        // Reset five cycles into RUN
        set_req(0, 7'h0A, 3'd3);
        req       = 2'b01;
        eng_delay = 200;
        wait_for(0, 20, cyc);
        req = 2'b00;
        wait_for(1, 20, cyc);
        step(5);
        reset = 1'b1;
        step(1);
        chk("rr_cs_high", 32'(cs_spi), 32'd1);
        chk("rr_gnt", 32'(gnt), 32'd0);
        chk("rr_done", 32'(done), 32'd0);
        chk("rr_err", 32'(err), 32'd0);
        step(1);
        reset = 1'b0;

        // Pointer must be back at 0: requester 0 wins a two-way tie
        set_req(0, 7'h01, 3'd0);
        set_req(1, 7'h02, 3'd0);
        req = 2'b11;
        push_exp(2'b01, 1'b0, 1'b0);
        step(1);
        chk("rr_ptr_gnt", 32'(gnt), 32'h1);
        req = 2'b10;
        push_exp(2'b10, 1'b0, 1'b0);
        step(2);
        chk("rr_next_gnt", 32'(gnt), 32'h2);
        req = 2'b00;
        step(3);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/spi_bus_arbiter.md
Name: spi_bus_arbiter

Overview:
- Clocked controller that shares the single SPI datapath (MOSI_spi/MISO_spi/SCA_spi engine) of the I2C-to-SPI adapter between NUM_REQ requesters, e.g. the I2C bridge and a local configuration port.
- Arbitrates round-robin and drives CS_spi and CS_address.
- Sequences each transaction: CS setup, engine start, completion or timeout, CS hold gap.
- Sits between the requesters and the SPI shift engine.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADD_range, 7, width of the slave address placed on CS_address.
- num_of_bytes_asked, 3, maximum transfer length in bytes; LEN_W = $clog2(num_of_bytes_asked+1).
- CS_SETUP, 2, cycles of CS_spi low before spi_start.
- CS_HOLD, 2, cycles of CS_spi high after each transfer before the next grant.
- TIMEOUT_CYCLES, 1024, maximum RUN cycles waiting for spi_done.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester request level
- req_addr  in  NUM_REQ*ADD_range  packed target address, slice i for requester i
- req_len  in  NUM_REQ*LEN_W  packed byte count, slice i
- gnt  out  NUM_REQ  one-hot grant
- done  out  NUM_REQ  one-cycle completion pulse to granted requester
- err  out  1  one-cycle pulse, coincident with done, on timeout or length overflow
- CS_address  out  ADD_range  latched address of the current transaction
- CS_spi  out  1  active-low chip select
- spi_start  out  1  one-cycle start pulse to the SPI engine
- spi_len  out  LEN_W  byte count for the engine, valid while CS_spi low
- spi_abort  out  1  one-cycle abort pulse to the engine
- spi_done  in  1  engine completion pulse

Behaviour:
- Reset values: gnt=0, done=0, err=0, CS_address=0, CS_spi=1, spi_start=0, spi_len=0, spi_abort=0, state=IDLE, rr pointer=0, counters=0. All outputs registered.
- States: IDLE, SETUP, RUN, HOLD.
- IDLE, on an edge where any req is set:
  - Pick the first set req at or after the rr pointer, with wrap-around.
  - Latch its addr/len; gnt set from the next cycle; rr pointer := winner+1 mod NUM_REQ.
  - len==0: no CS activity. Pulse done for the winner next cycle (gnt high that cycle only), then return to IDLE.
  - len > num_of_bytes_asked: done and err pulsed next cycle, no CS activity, return to IDLE.
  - Otherwise go to SETUP with CS_spi=0.
- SETUP: CS_spi low for exactly CS_SETUP cycles, then RUN.
- RUN:
  - spi_start high in the first RUN cycle only.
  - Timeout counter starts at 0 in the first RUN cycle.
  - spi_done seen -> HOLD; done pulse and CS_spi=1 in the first HOLD cycle.
  - Counter reaches TIMEOUT_CYCLES-1 without spi_done -> spi_abort, err and done all pulse in the first HOLD cycle.
  - spi_done and timeout on the same cycle: spi_done wins, no err.
- HOLD: CS_spi high for CS_HOLD cycles. gnt drops in the cycle after done. New requests are not sampled until IDLE.
- Latency: req sampled at edge k -> gnt and CS_spi low visible after edge k+1; spi_start after edge k+1+CS_SETUP.
- req is sampled only in IDLE. A requester dropping req mid-transfer does not abort the transfer; the transfer completes and done still pulses.
- spi_done outside RUN is ignored.
- Back-to-back: requester 0 holding req continuously while requester 1 waits -> grants alternate 0,1,0,...
- Reset mid-operation returns to reset values at the next edge: CS_spi high, no done/err pulse, rr pointer=0.
- Invariants: gnt is always one-hot or zero; gnt!=0 whenever CS_spi==0.

Decomposition:
- Package spi_arb_pkg holds:
  - arb_state_e enum (IDLE, SETUP, RUN, HOLD)
  - LEN_W helper function
  - timeout counter width constant
- Sub-module rr_priority_pick: combinational round-robin pick, inputs req + pointer, outputs one-hot winner + index. Instantiated once.

Test Plan:
- Single request: req[0]=1, addr=7'h2A, len=3, engine pulses spi_done 30 cycles after start -> gnt=01 and CS_spi=0 one cycle after request, spi_start 2 cycles later, CS_address=2A, done[0] and CS_spi=1 one cycle after spi_done, no new grant for 2 HOLD cycles.
- Contention: req=11 held continuously, len=1 each -> grant order 0,1,0,1, never two gnt bits high together.
- Timeout: engine never pulses spi_done -> spi_abort, err and done[1] pulse together 1024 cycles after spi_start, CS_spi high, arbiter returns to IDLE after HOLD.
- Boundary lengths: len=0 -> done pulse one cycle after grant, CS_spi stays 1, no spi_start; len=4 with num_of_bytes_asked=3 -> done+err, no CS activity.
- Reset mid-RUN: assert reset 5 cycles after spi_start -> next edge CS_spi=1, gnt=0, no done; a fresh req[1] afterwards is granted first (pointer=0, req[0] idle).
- Race: spi_done on the cycle the timeout would fire -> done without err, no spi_abort.
